// File: rtl/moxie_dbus_master.sv
// Wishbone classic data-bus master for the moxie core: queues load/store
// requests, runs one big-endian lane-steered bus cycle per entry, aborts stuck cycles.
module moxie_dbus_master #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    input  logic [3:0]  req_reg_index_i,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    output logic [3:0]  ld_reg_index_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [31:0] wb_D_adr_o,
    output logic [31:0] wb_D_dat_o,
    output logic [3:0]  wb_D_sel_o,
    output logic        wb_D_we_o,
    output logic        wb_D_cyc_o,
    output logic        wb_D_stb_o,
    input  logic [31:0] wb_D_dat_i,
    input  logic        wb_D_ack_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic [CW-1:0]  wd_q;

    logic           q_we   [DEPTH];
    logic [1:0]     q_size [DEPTH];
    logic [31:0]    q_addr [DEPTH];
    logic [31:0]    q_data [DEPTH];
    logic [3:0]     q_reg  [DEPTH];

    logic           accept, illegal, push, pop, ack_hit, timeout_hit;
    logic           head_we;
    logic [1:0]     head_size;
    logic [31:0]    head_addr, head_data;
    logic [3:0]     head_reg;
    logic [3:0]     head_sel;
    logic [31:0]    head_wdat, ld_ext;

    // Request handshake: a request transfers on the rising edge where
    // req_valid_i and req_ready_o are both high; ready is purely !full.
    assign req_ready_o = (count_q != CNT_FULL);
    assign accept      = req_valid_i & req_ready_o;
    assign illegal     = (req_size_i == 2'd3)
                       | ((req_size_i == 2'd1) & req_addr_i[0])
                       | ((req_size_i == 2'd2) & (req_addr_i[1:0] != 2'b00));
    assign push        = accept & ~illegal;

    assign head_we   = q_we[rd_ptr_q];
    assign head_size = q_size[rd_ptr_q];
    assign head_addr = q_addr[rd_ptr_q];
    assign head_data = q_data[rd_ptr_q];
    assign head_reg  = q_reg[rd_ptr_q];

    // Big-endian lanes: byte address 0 lives on dat[31:24].
    always_comb begin
        head_sel  = 4'b1111;
        head_wdat = head_data;
        ld_ext    = wb_D_dat_i;
        case (head_size)
            2'd0: begin
                head_sel  = 4'b1000 >> head_addr[1:0];
                head_wdat = {4{head_data[7:0]}};
                case (head_addr[1:0])
                    2'd0:    ld_ext = {24'h0, wb_D_dat_i[31:24]};
                    2'd1:    ld_ext = {24'h0, wb_D_dat_i[23:16]};
                    2'd2:    ld_ext = {24'h0, wb_D_dat_i[15:8]};
                    default: ld_ext = {24'h0, wb_D_dat_i[7:0]};
                endcase
            end
            2'd1: begin
                head_sel  = head_addr[1] ? 4'b0011 : 4'b1100;
                head_wdat = {2{head_data[15:0]}};
                ld_ext    = head_addr[1] ? {16'h0, wb_D_dat_i[15:0]}
                                         : {16'h0, wb_D_dat_i[31:16]};
            end
            default: begin
                head_sel  = 4'b1111;
                head_wdat = head_data;
                ld_ext    = wb_D_dat_i;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = BUS;
            end
            BUS: begin
                if (wb_D_ack_i) begin
                    ack_hit = 1'b1;
                    pop     = 1'b1;
                    if ((count_q == CNT_ONE) && !push) state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    timeout_hit = 1'b1;
                    pop         = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            wd_q           <= '0;
            ld_valid_o     <= 1'b0;
            ld_data_o      <= '0;
            ld_reg_index_o <= '0;
            err_o          <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Watchdog sits at zero outside BUS, so entering BUS starts from zero.
            if (state_q == BUS) wd_q <= wb_D_ack_i ? '0 : wd_q + 1'b1;
            else                wd_q <= '0;
            if (ack_hit && !head_we) begin
                ld_valid_o     <= 1'b1;
                ld_data_o      <= ld_ext;
                ld_reg_index_o <= head_reg;
            end else begin
                ld_valid_o     <= 1'b0;
            end
            err_o <= (accept & illegal) | timeout_hit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_we[wr_ptr_q]   <= req_we_i;
            q_size[wr_ptr_q] <= req_size_i;
            q_addr[wr_ptr_q] <= req_addr_i;
            q_data[wr_ptr_q] <= req_data_i;
            q_reg[wr_ptr_q]  <= req_reg_index_i;
        end
    end

    assign busy_o     = (count_q != '0) | (state_q == BUS);
    assign wb_D_stb_o = (state_q == BUS);
    assign wb_D_cyc_o = wb_D_stb_o;
    assign wb_D_adr_o = wb_D_stb_o ? {head_addr[31:2], 2'b00} : 32'h0;
    assign wb_D_dat_o = wb_D_stb_o ? head_wdat : 32'h0;
    assign wb_D_sel_o = wb_D_stb_o ? head_sel : 4'h0;
    assign wb_D_we_o  = wb_D_stb_o & head_we;

endmodule

// File: tb/tb_moxie_dbus_master.sv
// Directed bench for moxie_dbus_master: loads, stores, lane steering, illegal
// requests, queue-full back-pressure, watchdog abort and mid-cycle reset.
module tb_moxie_dbus_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_data_i = 32'h0;
    logic [3:0]  req_reg_index_i = 4'h0;
    logic        ld_valid_o;
    logic [31:0] ld_data_o;
    logic [3:0]  ld_reg_index_o;
    logic        err_o;
    logic        busy_o;
    logic [31:0] wb_D_adr_o;
    logic [31:0] wb_D_dat_o;
    logic [3:0]  wb_D_sel_o;
    logic        wb_D_we_o;
    logic        wb_D_cyc_o;
    logic        wb_D_stb_o;
    logic [31:0] wb_D_dat_i = 32'h0;
    logic        wb_D_ack_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    moxie_dbus_master #(.DEPTH(2), .TIMEOUT(4)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_we_i        (req_we_i),
        .req_size_i      (req_size_i),
        .req_addr_i      (req_addr_i),
        .req_data_i      (req_data_i),
        .req_reg_index_i (req_reg_index_i),
        .ld_valid_o      (ld_valid_o),
        .ld_data_o       (ld_data_o),
        .ld_reg_index_o  (ld_reg_index_o),
        .err_o           (err_o),
        .busy_o          (busy_o),
        .wb_D_adr_o      (wb_D_adr_o),
        .wb_D_dat_o      (wb_D_dat_o),
        .wb_D_sel_o      (wb_D_sel_o),
        .wb_D_we_o       (wb_D_we_o),
        .wb_D_cyc_o      (wb_D_cyc_o),
        .wb_D_stb_o      (wb_D_stb_o),
        .wb_D_dat_i      (wb_D_dat_i),
        .wb_D_ack_i      (wb_D_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] rg);
        req_valid_i     = 1'b1;
        req_we_i        = we;
        req_size_i      = size;
        req_addr_i      = addr;
        req_data_i      = data;
        req_reg_index_i = rg;
    endtask

    task automatic idle_req();
        req_valid_i = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, {31'h0, req_ready_o}, 32'h1);
        chk({tag, "_stb"},   {31'h0, wb_D_stb_o},  32'h0);
        chk({tag, "_cyc"},   {31'h0, wb_D_cyc_o},  32'h0);
        chk({tag, "_busy"},  {31'h0, busy_o},      32'h0);
        chk({tag, "_ldv"},   {31'h0, ld_valid_o},  32'h0);
        chk({tag, "_err"},   {31'h0, err_o},       32'h0);
        chk({tag, "_adr"},   wb_D_adr_o,           32'h0);
        chk({tag, "_sel"},   {28'h0, wb_D_sel_o},  32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_values("rst");
        chk("rst_ldata", ld_data_o, 32'h0);
        rst_i = 1'b0;
        tick();

        // Word load, slave acks on its 3rd cycle
        drive_req(1'b0, 2'd2, 32'h0000_1000, 32'h0, 4'd5);
        tick();
        idle_req();
        chk("wl_busy_q", {31'h0, busy_o}, 32'h1);
        chk("wl_stb_lat", {31'h0, wb_D_stb_o}, 32'h0);
        tick();
        chk("wl_stb", {31'h0, wb_D_stb_o}, 32'h1);
        chk("wl_cyc", {31'h0, wb_D_cyc_o}, 32'h1);
        chk("wl_adr", wb_D_adr_o, 32'h0000_1000);
        chk("wl_sel", {28'h0, wb_D_sel_o}, 32'hF);
        chk("wl_we", {31'h0, wb_D_we_o}, 32'h0);
        tick();
        chk("wl_stb2", {31'h0, wb_D_stb_o}, 32'h1);
        tick();
        wb_D_ack_i = 1'b1;
        wb_D_dat_i = 32'hDEAD_BEEF;
        tick();
        wb_D_ack_i = 1'b0;
        chk("wl_ldv", {31'h0, ld_valid_o}, 32'h1);
        chk("wl_ldata", ld_data_o, 32'hDEAD_BEEF);
        chk("wl_lreg", {28'h0, ld_reg_index_o}, 32'd5);
        chk("wl_stb_end", {31'h0, wb_D_stb_o}, 32'h0);
        tick();
        chk("wl_ldv_pulse", {31'h0, ld_valid_o}, 32'h0);
        chk("wl_busy_end", {31'h0, busy_o}, 32'h0);

        // Byte store, zero-wait slave
        drive_req(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 4'd0);
        tick();
        idle_req();
        tick();
        chk("bs_sel", {28'h0, wb_D_sel_o}, 32'h1);
        chk("bs_dat", wb_D_dat_o, 32'hA5A5_A5A5);
        chk("bs_we", {31'h0, wb_D_we_o}, 32'h1);
        chk("bs_adr", wb_D_adr_o, 32'h0000_1000);
        wb_D_ack_i = 1'b1;
        tick();
        wb_D_ack_i = 1'b0;
        chk("bs_no_ldv", {31'h0, ld_valid_o}, 32'h0);
        chk("bs_stb_end", {31'h0, wb_D_stb_o}, 32'h0);

        // Half loads back-to-back: 0x2002 then 0x2000
        drive_req(1'b0, 2'd1, 32'h0000_2002, 32'h0, 4'd3);
        tick();
        drive_req(1'b0, 2'd1, 32'h0000_2000, 32'h0, 4'd4);
        tick();
        idle_req();
        chk("hl_sel_lo", {28'h0, wb_D_sel_o}, 32'h3);
        chk("hl_adr", wb_D_adr_o, 32'h0000_2000);
        wb_D_ack_i = 1'b1;
        wb_D_dat_i = 32'h1122_3344;
        tick();
        chk("hl_stb_b2b", {31'h0, wb_D_stb_o}, 32'h1);
        chk("hl_sel_hi", {28'h0, wb_D_sel_o}, 32'hC);
        chk("hl_ld1", ld_data_o, 32'h0000_3344);
        chk("hl_reg1", {28'h0, ld_reg_index_o}, 32'd3);
        tick();
        wb_D_ack_i = 1'b0;
        chk("hl_ldv2", {31'h0, ld_valid_o}, 32'h1);
        chk("hl_ld2", ld_data_o, 32'h0000_1122);
        chk("hl_reg2", {28'h0, ld_reg_index_o}, 32'd4);
        chk("hl_stb_end", {31'h0, wb_D_stb_o}, 32'h0);
        tick();

        // Illegal requests: misaligned word, then size 3
        drive_req(1'b0, 2'd2, 32'h0000_1001, 32'h0, 4'd1);
        tick();
        chk("il_err1", {31'h0, err_o}, 32'h1);
        chk("il_busy1", {31'h0, busy_o}, 32'h0);
        drive_req(1'b0, 2'd3, 32'h0000_1000, 32'h0, 4'd1);
        tick();
        idle_req();
        chk("il_err2", {31'h0, err_o}, 32'h1);
        chk("il_stb", {31'h0, wb_D_stb_o}, 32'h0);
        tick();
        chk("il_err_clr", {31'h0, err_o}, 32'h0);
        chk("il_stb2", {31'h0, wb_D_stb_o}, 32'h0);
        chk("il_busy2", {31'h0, busy_o}, 32'h0);

        // Queue full: three loads offered, ack withheld at first
        drive_req(1'b0, 2'd2, 32'h0000_3000, 32'h0, 4'd1);
        tick();
        chk("qf_ready1", {31'h0, req_ready_o}, 32'h1);
        drive_req(1'b0, 2'd2, 32'h0000_3004, 32'h0, 4'd2);
        tick();
        chk("qf_ready_full", {31'h0, req_ready_o}, 32'h0);
        chk("qf_adr_a", wb_D_adr_o, 32'h0000_3000);
        drive_req(1'b0, 2'd2, 32'h0000_3008, 32'h0, 4'd3);
        tick();
        chk("qf_ready_full2", {31'h0, req_ready_o}, 32'h0);
        wb_D_ack_i = 1'b1;
        wb_D_dat_i = 32'hAAAA_0001;
        tick();
        wb_D_ack_i = 1'b0;
        chk("qf_ready_after_ack", {31'h0, req_ready_o}, 32'h1);
        chk("qf_ld_a", ld_data_o, 32'hAAAA_0001);
        chk("qf_reg_a", {28'h0, ld_reg_index_o}, 32'd1);
        chk("qf_adr_b", wb_D_adr_o, 32'h0000_3004);
        tick();
        idle_req();
        chk("qf_ready_full3", {31'h0, req_ready_o}, 32'h0);
        wb_D_ack_i = 1'b1;
        wb_D_dat_i = 32'hBBBB_0002;
        tick();
        chk("qf_ld_b", ld_data_o, 32'hBBBB_0002);
        chk("qf_reg_b", {28'h0, ld_reg_index_o}, 32'd2);
        chk("qf_adr_c", wb_D_adr_o, 32'h0000_3008);
        wb_D_dat_i = 32'hCCCC_0003;
        tick();
        wb_D_ack_i = 1'b0;
        chk("qf_ld_c", ld_data_o, 32'hCCCC_0003);
        chk("qf_reg_c", {28'h0, ld_reg_index_o}, 32'd3);
        chk("qf_stb_end", {31'h0, wb_D_stb_o}, 32'h0);
        tick();

        // Watchdog: TIMEOUT=4, slave never acks
        drive_req(1'b0, 2'd2, 32'h0000_4000, 32'h0, 4'd6);
        tick();
        idle_req();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_stb%0d", i), {31'h0, wb_D_stb_o}, 32'h1);
            chk($sformatf("to_noerr%0d", i), {31'h0, err_o}, 32'h0);
            tick();
        end
        chk("to_stb_drop", {31'h0, wb_D_stb_o}, 32'h0);
        chk("to_err", {31'h0, err_o}, 32'h1);
        chk("to_no_ldv", {31'h0, ld_valid_o}, 32'h0);
        tick();
        chk("to_err_pulse", {31'h0, err_o}, 32'h0);
        chk("to_busy", {31'h0, busy_o}, 32'h0);

        // Reset asserted during a pending cycle with a second entry queued
        drive_req(1'b0, 2'd2, 32'h0000_5000, 32'h0, 4'd7);
        tick();
        drive_req(1'b0, 2'd2, 32'h0000_5004, 32'h0, 4'd8);
        tick();
        idle_req();
        chk("mr_stb_before", {31'h0, wb_D_stb_o}, 32'h1);
        chk("mr_full_before", {31'h0, req_ready_o}, 32'h0);
        #2;
        rst_i = 1'b1;
        #1;
        chk_reset_values("mr_async");
        tick();
        chk("mr_ldv_held", {31'h0, ld_valid_o}, 32'h0);
        chk("mr_err_held", {31'h0, err_o}, 32'h0);
        rst_i = 1'b0;
        tick();
        tick();
        chk_reset_values("mr_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
